// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and single-outstanding imem fetch stage.
// Optional misaligned-target trap enabled by FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Clk_Enable,
  input  logic        PC_Sel,
  input  logic [31:0] Branch_Target,
  input  logic        Retire,
  output logic [31:0] Instruction,
  output logic        Instr_Valid,
  output logic [31:0] PC_Out,
  output logic [31:0] PC4_Out,
  output logic        Halted,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Gnt,
  input  logic [31:0] IMem_Rdata,
  input  logic        IMem_Rvalid,
  output logic        Fetch_Fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_FAULT,
`endif
    S_HALT
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic        halt_q, halt_d;
  logic        misalign;
  logic        take;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
  assign misalign = PC_Sel & (|Branch_Target[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign take = (state == S_HOLD) & Retire & Clk_Enable;

  // state register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= S_IDLE;
    else          state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (IMem_Gnt) state_d = S_WAIT;
      S_WAIT: if (IMem_Rvalid) state_d = S_HOLD;
      S_HOLD: begin
        if (Retire) begin
          if (!Clk_Enable) state_d = S_HALT;
          else if (misalign) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = S_FAULT;
`else
            state_d = S_REQ;
`endif
          end
          else state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if ((state == S_WAIT) && IMem_Rvalid)
      instr_d = IMem_Rdata;
    if (take) begin
      instr_d = NOP_INSTR;
      if (misalign)    pc_d = Branch_Target;
      else if (PC_Sel) pc_d = Branch_Target & ~32'h3;
      else             pc_d = pc_q + 32'd4;
    end
    valid_d = (state_d == S_HOLD) | (state_d == S_HALT);
    req_d   = (state_d == S_REQ);
    halt_d  = (state_d == S_HALT);
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d = (state_d == S_FAULT);
`endif
  end

  // output registers
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // trap flag register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end
  assign Fetch_Fault = fault_q;
`else
  assign Fetch_Fault = 1'b0;
`endif

  assign Instruction = instr_q;
  assign Instr_Valid = valid_q;
  assign PC_Out      = pc_q;
  assign PC4_Out     = pc_q + 32'd4;
  assign Halted      = halt_q;
  assign IMem_Req    = req_q;
  assign IMem_Addr   = {pc_q[31:2], 2'b00};

endmodule
